// File: rtl/tex_upload_arbiter_if.sv
// Upload/raster bus for the texture upload arbiter. The host/bench drives the
// command, data and raster-request inputs and sees the handshake and memory
// write outputs through the master modport. The arbiter uses the slave modport.
interface tex_upload_arbiter_if #(
  parameter int TEX_ADDR_W = 16
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_target;
  logic [15:0]           i_cmd_base;
  logic [15:0]           i_cmd_count;
  logic                  i_data_valid;
  logic                  o_data_ready;
  logic [23:0]           i_data;
  logic                  i_raster_req;
  logic                  o_raster_grant;
  logic                  o_tex_we;
  logic [TEX_ADDR_W-1:0] o_tex_address;
  logic [7:0]            o_tex_data;
  logic                  o_clut_we;
  logic [7:0]            o_clut_entry;
  logic [7:0]            o_clut_r;
  logic [7:0]            o_clut_g;
  logic [7:0]            o_clut_b;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_cmd_valid, i_cmd_target, i_cmd_base, i_cmd_count,
    output i_data_valid, i_data, i_raster_req,
    input  o_cmd_ready, o_data_ready, o_raster_grant,
    input  o_tex_we, o_tex_address, o_tex_data,
    input  o_clut_we, o_clut_entry, o_clut_r, o_clut_g, o_clut_b,
    input  o_busy, o_done
  );

  modport slave (
    input  i_cmd_valid, i_cmd_target, i_cmd_base, i_cmd_count,
    input  i_data_valid, i_data, i_raster_req,
    output o_cmd_ready, o_data_ready, o_raster_grant,
    output o_tex_we, o_tex_address, o_tex_data,
    output o_clut_we, o_clut_entry, o_clut_r, o_clut_g, o_clut_b,
    output o_busy, o_done
  );
endinterface

// File: rtl/tex_upload_arbiter.sv
// Texture/CLUT upload arbiter. Raster pixel issue owns the texture and CLUT
// RAMs while idle. An upload command stops raster issue, waits for the raster
// texture pipeline to drain, streams host words into the selected RAM with one
// registered write per accepted beat, then hands the RAMs back to raster.
module tex_upload_arbiter #(
  parameter int DRAIN_CYCLES = 4,
  parameter int TEX_ADDR_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  tex_upload_arbiter_if.slave  bus
);

  // Drain counter must hold DRAIN_CYCLES; keep at least one bit when it is 0/1.
  localparam int DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, XFER, DONE} state_t;

  state_t                state_reg, state_next;
  logic [DCNT_W-1:0]     drain_reg, drain_next;
  logic [15:0]           index_reg, index_next;
  logic                  target_reg;
  logic [15:0]           base_reg;
  logic [15:0]           count_reg;
  logic                  cmd_accept;
  logic                  beat;
  logic                  cmd_ready;
  logic                  data_ready;
  logic                  grant;

  logic                  tex_we_reg;
  logic [TEX_ADDR_W-1:0] tex_address_reg;
  logic [7:0]            tex_data_reg;
  logic                  clut_we_reg;
  logic [7:0]            clut_entry_reg;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state, handshakes and raster grant; the command wins a same-cycle tie.
  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    index_next = index_reg;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    grant      = 1'b0;
    cmd_accept = 1'b0;
    beat       = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        grant     = bus.i_raster_req & ~bus.i_cmd_valid;
        if (bus.i_cmd_valid) begin
          cmd_accept = 1'b1;
          index_next = '0;
          drain_next = DCNT_W'(DRAIN_CYCLES);
          state_next = (DRAIN_CYCLES == 0) ? XFER : DRAIN;
        end
      end
      DRAIN: begin
        drain_next = drain_reg - 1'b1;
        if (drain_reg == DCNT_W'(1)) state_next = XFER;
      end
      XFER: begin
        data_ready = 1'b1;
        if (bus.i_data_valid) begin
          beat       = 1'b1;
          index_next = index_reg + 16'd1;
          if (index_reg == count_reg) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drain counter, beat index and the latched command fields.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      drain_reg  <= '0;
      index_reg  <= '0;
      target_reg <= 1'b0;
      base_reg   <= '0;
      count_reg  <= '0;
    end else begin
      drain_reg <= drain_next;
      index_reg <= index_next;
      if (cmd_accept) begin
        target_reg <= bus.i_cmd_target;
        base_reg   <= bus.i_cmd_base;
        count_reg  <= bus.i_cmd_count;
      end
    end
  end

  // Registered write port: one strobe per accepted beat, address/data hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tex_we_reg      <= 1'b0;
      tex_address_reg <= '0;
      tex_data_reg    <= '0;
      clut_we_reg     <= 1'b0;
      clut_entry_reg  <= '0;
    end else begin
      tex_we_reg  <= beat & ~target_reg;
      clut_we_reg <= beat & target_reg;
      if (beat & ~target_reg) begin
        tex_address_reg <= TEX_ADDR_W'(base_reg) + TEX_ADDR_W'(index_reg);
        tex_data_reg    <= bus.i_data[7:0];
      end
      if (beat & target_reg) begin
        clut_entry_reg <= base_reg[7:0] + index_reg[7:0];
      end
    end
  end

  // One colour channel register per byte lane: 0 = b, 1 = g, 2 = r.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] chan_reg;
      // Capture this lane of the word on each accepted CLUT beat.
      always_ff @(posedge i_clk) begin
        if (i_reset)                 chan_reg <= '0;
        else if (beat & target_reg)  chan_reg <= bus.i_data[gi*8 +: 8];
      end
    end
  endgenerate

  assign bus.o_cmd_ready    = cmd_ready;
  assign bus.o_data_ready   = data_ready;
  assign bus.o_raster_grant = grant;
  assign bus.o_tex_we       = tex_we_reg;
  assign bus.o_tex_address  = tex_address_reg;
  assign bus.o_tex_data     = tex_data_reg;
  assign bus.o_clut_we      = clut_we_reg;
  assign bus.o_clut_entry   = clut_entry_reg;
  assign bus.o_clut_b       = g_chan[0].chan_reg;
  assign bus.o_clut_g       = g_chan[1].chan_reg;
  assign bus.o_clut_r       = g_chan[2].chan_reg;
  assign bus.o_busy         = (state_reg != IDLE);
  assign bus.o_done         = (state_reg == DONE);

endmodule

// File: tb/tb_tex_upload_arbiter.sv
// Bench for tex_upload_arbiter: directed upload table, a reset-abort sequence
// and randomized uploads checked cycle by cycle against a timeline model.
module tb_tex_upload_arbiter;
  localparam int DRAIN = 4;
  localparam int AW    = 16;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  tex_upload_arbiter_if #(.TEX_ADDR_W(AW)) bus ();

  tex_upload_arbiter #(.DRAIN_CYCLES(DRAIN), .TEX_ADDR_W(AW)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model of the values the write port should currently hold.
  logic [15:0] m_tex_addr;
  logic [7:0]  m_tex_data;
  logic [7:0]  m_entry;
  logic [23:0] m_rgb;

  // Expected writes of the current upload, and an optional data_valid pattern.
  logic [23:0] q_words[$];
  logic [15:0] q_addr[$];
  bit          q_vpat[$];

  typedef struct {
    bit              tgt;
    logic [15:0]     base;
    logic [15:0]     cnt;
    logic [3:0][23:0] d;
    logic [3:0][15:0] a;
    bit   [5:0]      vpat;
    int              vlen;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle(input bit eg, input bit ecr, input bit edr, input bit eb,
                             input bit ed, input bit etw, input bit ecw);
    chk("raster_grant", 32'(bus.o_raster_grant), 32'(eg));
    chk("cmd_ready",    32'(bus.o_cmd_ready),    32'(ecr));
    chk("data_ready",   32'(bus.o_data_ready),   32'(edr));
    chk("busy",         32'(bus.o_busy),         32'(eb));
    chk("done",         32'(bus.o_done),         32'(ed));
    chk("tex_we",       32'(bus.o_tex_we),       32'(etw));
    chk("clut_we",      32'(bus.o_clut_we),      32'(ecw));
    chk("tex_address",  32'(bus.o_tex_address),  32'(m_tex_addr));
    chk("tex_data",     32'(bus.o_tex_data),     32'(m_tex_data));
    chk("clut_entry",   32'(bus.o_clut_entry),   32'(m_entry));
    chk("clut_rgb",     32'({bus.o_clut_r, bus.o_clut_g, bus.o_clut_b}), 32'(m_rgb));
  endtask

  task automatic drive(input bit cv, input bit tgt, input logic [15:0] base,
                       input logic [15:0] cnt, input bit dv, input logic [23:0] d,
                       input bit req);
    bus.i_cmd_valid  = cv;
    bus.i_cmd_target = tgt;
    bus.i_cmd_base   = base;
    bus.i_cmd_count  = cnt;
    bus.i_data_valid = dv;
    bus.i_data       = d;
    bus.i_raster_req = req;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_write(input bit tgt, input int idx);
    if (!tgt) begin
      m_tex_addr = q_addr[idx];
      m_tex_data = q_words[idx][7:0];
    end else begin
      m_entry = q_addr[idx][7:0];
      m_rgb   = q_words[idx];
    end
  endtask

  task automatic model_reset();
    m_tex_addr = '0; m_tex_data = '0; m_entry = '0; m_rgb = '0;
  endtask

  // Idle cycle: grant follows the request, stray data beats are ignored.
  task automatic idle_cycle(input bit req);
    next_cycle();
    drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 24'($urandom), req);
    @(negedge i_clk);
    check_cycle(req, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One upload: accept cycle, DRAIN cycles, beats, DONE. abort_after >= 0 pulses
  // reset once that many beats have been accepted.
  task automatic run_txn(input bit tgt, input logic [15:0] base, input logic [15:0] cnt,
                         input int abort_after);
    int nbeats; int k; int pidx; bit pend; bit v;
    nbeats = int'(cnt) + 1; k = 0; pidx = 0; pend = 1'b0;
    next_cycle();
    drive(1'b1, tgt, base, cnt, 1'($urandom), 24'($urandom), 1'b1);
    @(negedge i_clk);
    check_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < DRAIN; d++) begin
      next_cycle();
      drive(1'($urandom), ~tgt, 16'($urandom), 16'($urandom), 1'($urandom), 24'($urandom), 1'($urandom));
      @(negedge i_clk);
      check_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    while (k < nbeats) begin
      if (abort_after >= 0 && k == abort_after) begin
        next_cycle();
        i_reset = 1'b1;
        drive(1'b0, tgt, base, cnt, 1'b1, q_words[k], 1'($urandom));
        @(negedge i_clk);
        if (pend) apply_write(tgt, pidx);
        check_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pend & ~tgt, pend & tgt);
        model_reset();
        next_cycle();
        i_reset = 1'b0;
        drive(1'b0, tgt, base, cnt, 1'($urandom), 24'($urandom), 1'b1);
        @(negedge i_clk);
        check_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        q_vpat.delete();
        return;
      end
      if (q_vpat.size() > 0) v = q_vpat.pop_front();
      else                   v = ($urandom_range(99) < 65);
      next_cycle();
      drive(1'b0, tgt, base, cnt, v, v ? q_words[k] : 24'($urandom), 1'($urandom));
      @(negedge i_clk);
      if (pend) apply_write(tgt, pidx);
      check_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pend & ~tgt, pend & tgt);
      pend = v; pidx = k;
      if (v) k++;
    end
    next_cycle();
    drive(1'b0, tgt, base, cnt, 1'($urandom), 24'($urandom), 1'($urandom));
    @(negedge i_clk);
    apply_write(tgt, pidx);
    check_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ~tgt, tgt);
    q_vpat.delete();
  endtask

  // Expected writes from the addressing rules: texture wraps at 2^16, CLUT at 256.
  task automatic build_random(input bit tgt, input logic [15:0] base, input logic [15:0] cnt);
    q_words.delete(); q_addr.delete(); q_vpat.delete();
    for (int k = 0; k <= int'(cnt); k++) begin
      q_words.push_back(24'($urandom));
      if (tgt) q_addr.push_back({8'h00, 8'((int'(base[7:0]) + k) % 256)});
      else     q_addr.push_back(16'((int'(base) + k) % 65536));
    end
  endtask

  initial begin
    bit          tgt;
    logic [15:0] base;
    logic [15:0] cnt;

    tbl[0] = '{1'b0, 16'hFFFE, 16'd3, {24'hFF0044, 24'h000033, 24'h123422, 24'hABCD11},
               {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}, 6'b001111, 4};
    tbl[1] = '{1'b1, 16'h00FF, 16'd1, {24'h0, 24'h0, 24'h010203, 24'hAABBCC},
               {16'h0, 16'h0, 16'h0000, 16'h00FF}, 6'b000011, 2};
    tbl[2] = '{1'b0, 16'h1234, 16'd0, {24'h0, 24'h0, 24'h0, 24'h77665A},
               {16'h0, 16'h0, 16'h0, 16'h1234}, 6'b0, 0};
    tbl[3] = '{1'b1, 16'hABFE, 16'd3, {24'h445566, 24'h112233, 24'hFFFFFF, 24'h808080},
               {16'h0001, 16'h0000, 16'h00FF, 16'h00FE}, 6'b0, 0};
    tbl[4] = '{1'b0, 16'h7FFF, 16'd2, {24'h0, 24'h0000C3, 24'h0000B2, 24'h0000A1},
               {16'h0, 16'h8001, 16'h8000, 16'h7FFF}, 6'b101001, 6};

    model_reset();
    i_reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 24'h0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    check_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Idle raster grant follows the request every cycle.
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b1);

    // Directed uploads from the table; even rows are followed by an idle
    // cycle, odd rows go back-to-back into the next command.
    for (int i = 0; i < 5; i++) begin
      q_words.delete(); q_addr.delete(); q_vpat.delete();
      for (int k = 0; k <= int'(tbl[i].cnt); k++) begin
        q_words.push_back(tbl[i].d[k]);
        q_addr.push_back(tbl[i].a[k]);
      end
      for (int j = 0; j < tbl[i].vlen; j++) q_vpat.push_back(tbl[i].vpat[j]);
      run_txn(tbl[i].tgt, tbl[i].base, tbl[i].cnt, -1);
      if (i % 2 == 0) idle_cycle(1'b1);
    end

    // Reset after 2 of 8 texture beats, then a normal upload.
    build_random(1'b0, 16'h0100, 16'd7);
    q_vpat.push_back(1'b1); q_vpat.push_back(1'b1);
    run_txn(1'b0, 16'h0100, 16'd7, 2);
    build_random(1'b1, 16'h00FE, 16'd4);
    run_txn(1'b1, 16'h00FE, 16'd4, -1);
    idle_cycle(1'b1);

    // Randomized uploads, with an occasional reset abort and idle gaps.
    for (int i = 0; i < 24; i++) begin
      tgt  = 1'($urandom);
      base = 16'($urandom);
      if (i % 5 == 0) base = tgt ? 16'h00FC : 16'hFFFC;
      cnt  = 16'($urandom_range(0, 9));
      build_random(tgt, base, cnt);
      if (i % 7 == 6) run_txn(tgt, base, cnt, $urandom_range(0, int'(cnt)));
      else            run_txn(tgt, base, cnt, -1);
      for (int j = $urandom_range(0, 2); j > 0; j--) idle_cycle(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tex_upload_arbiter.md
Name: tex_upload_arbiter

Overview:
Shares the texture RAM and colour LUT RAM between the textured raster pipeline and a host upload stream. While no upload is active, the raster front end is granted pixel issue. On an upload command, the block stops raster issue and waits for in-flight pixels to drain. It then streams host words into texture RAM (8-bit texel indices) or the CLUT (24-bit RGB), and releases the raster side when the upload completes.

Parameters:
DRAIN_CYCLES, 4, cycles to wait after the raster grant drops before the first memory write (raster texture pipeline depth); 0 means no wait.
TEX_ADDR_W, 16, texture RAM address width.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_cmd_valid  in  1  upload command present
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_target  in  1  0 = texture RAM, 1 = CLUT
i_cmd_base  in  16  first address (CLUT uses [7:0])
i_cmd_count  in  16  number of words minus one
i_data_valid  in  1  upload word present
o_data_ready  out  1  word accepted when valid&ready
i_data  in  24  word: texture uses [7:0]; CLUT {r[23:16],g[15:8],b[7:0]}
i_raster_req  in  1  raster front end wants to issue a pixel
o_raster_grant  out  1  pixel may enter the pipeline this cycle
o_tex_we  out  1  texture RAM write strobe
o_tex_address  out  TEX_ADDR_W  texture write address
o_tex_data  out  8  texture write data
o_clut_we  out  1  CLUT write strobe
o_clut_entry  out  8  CLUT write entry
o_clut_r / o_clut_g / o_clut_b  out  8 each  CLUT write colour
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at upload completion

Behaviour:
- Reset values: state IDLE; every registered output 0; o_cmd_ready 1 after reset (IDLE).
- States: IDLE, DRAIN, XFER, DONE.
- IDLE:
  - o_cmd_ready = 1.
  - o_raster_grant = i_raster_req & ~i_cmd_valid. The command wins the same-cycle tie, so the raster grant is 0 in the acceptance cycle.
  - On accept: latch target, base, and count; clear the beat index; load the drain counter with DRAIN_CYCLES; go to DRAIN, or straight to XFER if DRAIN_CYCLES == 0.
- DRAIN:
  - Grant 0, cmd_ready 0, data_ready 0.
  - Decrement the counter each cycle; move to XFER in the cycle the counter reaches 1.
  - Result: exactly DRAIN_CYCLES cycles are spent in DRAIN.
- XFER:
  - o_data_ready = 1; grant 0.
  - Each accepted beat registers one write, visible the next cycle (latency 1).
  - Texture target: o_tex_address = base + index, modulo 2^TEX_ADDR_W; o_tex_data = i_data[7:0].
  - CLUT target: o_clut_entry = base[7:0] + index[7:0], modulo 256; r/g/b taken from i_data.
  - Only the strobe of the selected target rises; the other target's strobe stays 0.
  - Cycles with i_data_valid low produce no write (strobe 0, address/data hold).
  - When the accepted beat has index == count: go to DONE (count+1 beats total; count = 0xFFFF gives 65536 beats).
- DONE:
  - Lasts one cycle; o_done = 1; the final write strobe is visible in this cycle; grant 0; data_ready 0.
  - Then IDLE. A new command is accepted in the first IDLE cycle, with no back-to-back gap beyond DONE.
- Write strobes are single-cycle per accepted beat; they are never asserted outside the cycle after an XFER beat.
- o_busy = 1 in DRAIN, XFER, and DONE.
- i_raster_req is ignored outside IDLE; no request is queued.
- Reset mid-operation: return to IDLE next edge. Any write registered in the reset cycle is dropped (strobes forced 0). Words already written stay in RAM. No o_done is produced.
- Data beats offered while in IDLE or DRAIN are not accepted (data_ready 0).

Test Plan:
- Texture wrap: cmd target 0, base 0xFFFE, count 3, data 0x11,0x22,0x33,0x44 back-to-back → o_tex_we on 4 consecutive cycles at addresses FFFE, FFFF, 0000, 0001 with matching data; o_done 1 cycle after the last beat; o_clut_we never 1.
- CLUT wrap: target 1, base 0x00FF, count 1, data 0xAABBCC, 0x010203 → entry FF = (AA,BB,CC), entry 00 = (01,02,03); o_tex_we never 1.
- Drain timing: DRAIN_CYCLES 4; cmd accepted at cycle 0 with i_raster_req held 1 → grant 0 from cycle 0; o_data_ready first 1 at cycle 5; grant returns to 1 the cycle after o_done.
- Gapped data: count 2, data_valid pattern 1,0,0,1,0,1 → exactly 3 writes, at consecutive addresses, each strobe 1 cycle; DONE entered only after the 3rd beat.
- Tie and idle grant: idle with i_raster_req 1 → grant 1 every cycle; assert i_cmd_valid in the same cycle as i_raster_req → grant 0 that cycle, command accepted.
- Reset mid-XFER: after 2 of 8 beats, pulse i_reset → next cycle IDLE, o_busy 0, no strobe, no o_done; a new command is then accepted and completes normally.
